// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, registered sync/de decode, delay line.
// Optional colour-bar source enabled by defining VTG_PATTERN_EN.
module video_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 11,
    parameter int PIPE_LAT = 2
) (
    input  logic          pixclk,
    input  logic          n_rst,
    input  logic          en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          hs,
    output logic          vs,
    output logic          sof,
    output logic          eol,
    output logic          de_d,
    output logic          hs_d,
    output logic          vs_d,
    output logic [7:0]    pat_r,
    output logic [7:0]    pat_g,
    output logic [7:0]    pat_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam logic HS_ON  = (HS_POL != 0);
    localparam logic VS_ON  = (VS_POL != 0);
    localparam logic HS_OFF = !HS_ON;
    localparam logic VS_OFF = !VS_ON;

`ifdef VTG_PATTERN_EN
    localparam int DW    = 27;
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
`else
    localparam int DW    = 3;
`endif
    localparam logic [DW-1:0] TAP_OFF = {{(DW-2){1'b0}}, HS_OFF, VS_OFF};

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_act;
    logic          v_act;
    logic          h_syn;
    logic          v_syn;
    logic [DW-1:0] tap_in;
    logic [DW-1:0] tap_out;

    always_ff @(posedge pixclk or negedge n_rst) begin
        if (!n_rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == CW'(H_TOTAL - 1)) begin
            hcnt <= '0;
            vcnt <= (vcnt == CW'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign h_act = (hcnt < CW'(H_ACTIVE));
    assign v_act = (vcnt < CW'(V_ACTIVE));
    assign h_syn = (hcnt >= CW'(HS_BEG)) && (hcnt < CW'(HS_END));
    assign v_syn = (vcnt >= CW'(VS_BEG)) && (vcnt < CW'(VS_END));

    // en gates the decode so a disabled cycle registers the idle state
    always_ff @(posedge pixclk or negedge n_rst) begin
        if (!n_rst) begin
            x   <= '0;
            y   <= '0;
            de  <= 1'b0;
            sof <= 1'b0;
            eol <= 1'b0;
            hs  <= HS_OFF;
            vs  <= VS_OFF;
        end else begin
            x   <= hcnt;
            y   <= vcnt;
            de  <= en && h_act && v_act;
            sof <= en && (hcnt == '0) && (vcnt == '0);
            eol <= en && h_act && v_act && (hcnt == CW'(H_ACTIVE - 1));
            hs  <= (en && h_syn) ? HS_ON : HS_OFF;
            vs  <= (en && v_syn) ? VS_ON : VS_OFF;
        end
    end

`ifdef VTG_PATTERN_EN
    logic [CW-1:0] bar;
    logic [2:0]    idx;
    logic [23:0]   pix;

    assign bar = x / CW'(BAR_W);
    assign idx = (bar > CW'(7)) ? 3'd7 : bar[2:0];
    // bar index bits map to inverted g/r/b so the order is W Y C G M R B K
    assign pix = de ? {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}} : 24'h0;
    assign tap_in = {pix, de, hs, vs};
    assign {pat_r, pat_g, pat_b} = tap_out[26:3];
`else
    assign tap_in = {de, hs, vs};
    assign pat_r = 8'h00;
    assign pat_g = 8'h00;
    assign pat_b = 8'h00;
`endif

    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign tap_out = tap_in;
        end else begin : g_dly
            logic [DW-1:0] sr [PIPE_LAT];
            always_ff @(posedge pixclk or negedge n_rst) begin
                if (!n_rst) begin
                    for (int i = 0; i < PIPE_LAT; i++) sr[i] <= TAP_OFF;
                end else begin
                    sr[0] <= tap_in;
                    for (int i = 1; i < PIPE_LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign tap_out = sr[PIPE_LAT-1];
        end
    endgenerate

    assign de_d = tap_out[2];
    assign hs_d = tap_out[1];
    assign vs_d = tap_out[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster, frame-position model, random en.
module tb_video_timing_gen;

    localparam int HA = 16, HF = 2, HSW = 3, HB = 4, HT = 25;
    localparam int VA = 6, VF = 1, VSW = 2, VB = 2, VT = 11;
    localparam int FR = HT * VT;

    logic pixclk = 1'b0;
    logic n_rst  = 1'b1;
    logic en     = 1'b0;
    bit   started = 1'b0;

    logic [10:0] a_x, a_y, b_x, b_y;
    logic a_de, a_hs, a_vs, a_sof, a_eol, a_ded, a_hsd, a_vsd;
    logic b_de, b_hs, b_vs, b_sof, b_eol, b_ded, b_hsd, b_vsd;
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;

    int checks = 0;
    int errors = 0;

    always #5 pixclk = ~pixclk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .CW(11), .PIPE_LAT(3)
    ) u_a (
        .pixclk(pixclk), .n_rst(n_rst), .en(en),
        .x(a_x), .y(a_y), .de(a_de), .hs(a_hs), .vs(a_vs),
        .sof(a_sof), .eol(a_eol),
        .de_d(a_ded), .hs_d(a_hsd), .vs_d(a_vsd),
        .pat_r(a_r), .pat_g(a_g), .pat_b(a_b)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1), .VS_POL(1), .CW(11), .PIPE_LAT(0)
    ) u_b (
        .pixclk(pixclk), .n_rst(n_rst), .en(en),
        .x(b_x), .y(b_y), .de(b_de), .hs(b_hs), .vs(b_vs),
        .sof(b_sof), .eol(b_eol),
        .de_d(b_ded), .hs_d(b_hsd), .vs_d(b_vsd),
        .pat_r(b_r), .pat_g(b_g), .pat_b(b_b)
    );

    typedef struct {
        bit de; bit hs; bit vs; bit sof; bit eol; int x; int y;
    } exp_t;

    localparam exp_t IDLE = '{de: 0, hs: 0, vs: 0, sof: 0, eol: 0, x: 0, y: 0};
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int   pos;
    exp_t cur;
    exp_t hist [$];

    // Model: frame position advances while enabled; outputs from position.
    always @(posedge pixclk or negedge n_rst) begin
        if (!n_rst) begin
            pos = 0;
            cur = IDLE;
            hist = {IDLE, IDLE, IDLE, IDLE};
        end else begin
            if (en) begin
                int h, v;
                h = pos % HT;
                v = pos / HT;
                cur.de  = (h < HA) && (v < VA);
                cur.hs  = (h >= HA + HF) && (h < HA + HF + HSW);
                cur.vs  = (v >= VA + VF) && (v < VA + VF + VSW);
                cur.sof = (pos == 0);
                cur.eol = cur.de && (h == HA - 1);
                cur.x   = h;
                cur.y   = v;
                pos = (pos + 1) % FR;
            end else begin
                cur = IDLE;
                pos = 0;
            end
            hist.push_front(cur);
            if (hist.size() > 4) void'(hist.pop_back());
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string id, input logic de, input logic hs,
                           input logic vs, input logic sof, input logic eol,
                           input logic [10:0] x, input logic [10:0] y,
                           input logic ded, input logic hsd, input logic vsd,
                           input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input bit pol, input int lat);
        exp_t e, d;
        logic [23:0] ep;
        e = cur;
        d = hist[lat];
        chk({id, " de"}, int'(de), int'(e.de));
        chk({id, " hs"}, int'(hs), int'(e.hs ? pol : !pol));
        chk({id, " vs"}, int'(vs), int'(e.vs ? pol : !pol));
        chk({id, " sof"}, int'(sof), int'(e.sof));
        chk({id, " eol"}, int'(eol), int'(e.eol));
        if (e.de) begin
            chk({id, " x"}, int'(x), e.x);
            chk({id, " y"}, int'(y), e.y);
        end
        chk({id, " de_d"}, int'(ded), int'(d.de));
        chk({id, " hs_d"}, int'(hsd), int'(d.hs ? pol : !pol));
        chk({id, " vs_d"}, int'(vsd), int'(d.vs ? pol : !pol));
`ifdef VTG_PATTERN_EN
        ep = d.de ? bars[d.x / (HA / 8)] : 24'h0;
`else
        ep = 24'h0;
`endif
        chk({id, " pat"}, int'({r, g, b}), int'(ep));
    endtask

    always @(negedge pixclk) begin
        if (n_rst && started) begin
            chk_dut("A", a_de, a_hs, a_vs, a_sof, a_eol, a_x, a_y,
                    a_ded, a_hsd, a_vsd, a_r, a_g, a_b, 1'b0, 3);
            chk_dut("B", b_de, b_hs, b_vs, b_sof, b_eol, b_x, b_y,
                    b_ded, b_hsd, b_vsd, b_r, b_g, b_b, 1'b1, 0);
        end
    end

    initial begin
        int sof_t [$];
        int de_rise, de_len, hs_rise, hs_len, vs_rise, vs_len, eol_n, bhs_len;
        bit de_done, hs_done, vs_done, bhs_done;
        int first_pat;

        #3 n_rst = 1'b0;
        repeat (3) @(negedge pixclk);
        chk("rst de", int'(a_de), 0);
        chk("rst sof", int'(a_sof), 0);
        chk("rst eol", int'(a_eol), 0);
        chk("rst hs A", int'(a_hs), 1);
        chk("rst vs A", int'(a_vs), 1);
        chk("rst hs B", int'(b_hs), 0);
        chk("rst vs B", int'(b_vs), 0);
        chk("rst hs_d A", int'(a_hsd), 1);
        chk("rst de_d A", int'(a_ded), 0);
        chk("rst pat", int'({a_r, a_g, a_b}), 0);
        n_rst = 1'b1;
        repeat (2) @(negedge pixclk);
        started = 1'b1;

        // Directed: two full frames with en held high.
        en = 1'b1;
        de_rise = -1; hs_rise = -1; vs_rise = -1;
        de_len = 0; hs_len = 0; vs_len = 0; eol_n = 0; bhs_len = 0;
        de_done = 0; hs_done = 0; vs_done = 0; bhs_done = 0;
        first_pat = -1;
        for (int k = 1; k <= 2 * FR; k++) begin
            @(negedge pixclk);
            if (a_sof) sof_t.push_back(k);
            if (de_rise < 0 && a_de) de_rise = k;
            if (de_rise >= 0 && !de_done) begin
                if (a_de) de_len++; else de_done = 1;
            end
            if (hs_rise < 0 && !a_hs) hs_rise = k;
            if (hs_rise >= 0 && !hs_done) begin
                if (!a_hs) hs_len++; else hs_done = 1;
            end
            if (vs_rise < 0 && !a_vs) vs_rise = k;
            if (vs_rise >= 0 && !vs_done) begin
                if (!a_vs) vs_len++; else vs_done = 1;
            end
            if (b_hs) begin
                if (!bhs_done) bhs_len++;
            end else if (bhs_len > 0) begin
                bhs_done = 1;
            end
            if (k <= FR && a_eol) eol_n++;
            if (first_pat < 0 && a_ded) first_pat = int'({a_r, a_g, a_b});
        end
        chk("sof count", sof_t.size(), 2);
        if (sof_t.size() >= 2) begin
            chk("sof first", sof_t[0], 1);
            chk("frame period", sof_t[1] - sof_t[0], FR);
            chk("vs start", vs_rise - sof_t[0], (VA + VF) * HT);
        end
        chk("de run", de_len, 16);
        chk("de rise", de_rise, 1);
        chk("hs offset", hs_rise - de_rise, 18);
        chk("hs width A", hs_len, 3);
        chk("hs width B", bhs_len, 3);
        chk("vs width", vs_len, 50);
        chk("eol per frame", eol_n, 6);
`ifdef VTG_PATTERN_EN
        chk("first pat", first_pat, 24'hFFFFFF);
`else
        chk("first pat", first_pat, 0);
`endif

        // Directed: abort mid-frame, hold off 50 cycles, restart.
        repeat (3 * HT + 5) @(negedge pixclk);
        en = 1'b0;
        @(negedge pixclk);
        chk("abort de", int'(a_de), 0);
        chk("abort hs", int'(a_hs), 1);
        chk("abort vs", int'(a_vs), 1);
        repeat (49) @(negedge pixclk);
        en = 1'b1;
        @(negedge pixclk);
        chk("restart sof", int'(a_sof), 1);
        chk("restart de", int'(a_de), 1);

        // Random: mostly enabled with occasional dropouts.
        for (int c = 0; c < 4000; c++) begin
            @(negedge pixclk);
            if ($urandom_range(0, 299) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 40)) @(negedge pixclk);
                en = 1'b1;
            end
        end
        @(negedge pixclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
